// File: rtl/prv32_muldiv_seq_if.sv
// prv32_muldiv_seq_if: request/response bundle between the execute stage and the RV32M sequencer
interface prv32_muldiv_seq_if #(parameter int XLEN = 32);
    logic            start, kill, ready, busy, done;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a, b, result;
    modport master(output start, kill, funct3, a, b, input ready, busy, done, result);
    modport slave(input start, kill, funct3, a, b, output ready, busy, done, result);
endinterface

// File: rtl/prv32_muldiv_seq.sv
// prv32_muldiv_seq: iterative RV32M sequencer, radix-2 shift-add multiply and restoring divide
module prv32_muldiv_seq #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst_n,
    prv32_muldiv_seq_if.slave io
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic [1:0]        state, nstate;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              nq, nr, a_s, b_s, sa, sb, is_div, dz, ovf, spec, accept, ge;
    logic [2*XLEN-1:0] acc, acc_step, prod;
    logic [XLEN-1:0]   opb, ma, mb, q, r, rd, fix_res, spec_res, res;
    logic [XLEN:0]     msum, rs;
    always_comb begin
        a_s      = ~(io.funct3[0] & (io.funct3[1] | io.funct3[2]));
        b_s      = a_s & ~(io.funct3[1] & ~io.funct3[2]);
        sa       = a_s & io.a[XLEN-1];
        sb       = b_s & io.b[XLEN-1];
        ma       = sa ? -io.a : io.a;
        mb       = sb ? -io.b : io.b;
        is_div   = io.funct3[2];
        dz       = is_div & (io.b == '0);
        ovf      = is_div & ~io.funct3[0] & (io.a == MIN) & (io.b == '1);
        spec     = dz | ovf;
        spec_res = dz ? (io.funct3[1] ? io.a : '1) : (io.funct3[1] ? '0 : MIN);
        accept   = io.ready & io.start & ~io.kill;
        // multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}
        msum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        rs       = acc[2*XLEN-1:XLEN-1];
        ge       = rs >= {1'b0, opb};
        rd       = rs[XLEN-1:0] - opb;
        acc_step = f3[2] ? {ge ? rd : rs[XLEN-1:0], acc[XLEN-2:0], ge}
                         : (acc[0] ? {msum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]});
        prod     = nq ? -acc : acc;
        q        = nq ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r        = nr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res  = f3[2] ? (f3[1] ? r : q) : (f3 == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        nstate   = io.kill ? IDLE
                 : accept ? (spec ? DONE : CALC)
                 : state == CALC ? (cnt == CW'(XLEN-1) ? FIX : CALC)
                 : state == FIX ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            f3    <= '0;
            nq    <= 1'b0;
            nr    <= 1'b0;
            acc   <= '0;
            opb   <= '0;
            res   <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                f3  <= io.funct3;
                nq  <= sa ^ sb;
                nr  <= sa;
                cnt <= '0;
                acc <= {{XLEN{1'b0}}, is_div ? ma : mb};
                opb <= is_div ? mb : ma;
                if (spec) res <= spec_res;
            end else if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end else if (state == FIX && !io.kill) res <= fix_res;
        end
    assign io.ready  = (state == IDLE) | (state == DONE);
    assign io.busy   = (state == CALC) | (state == FIX);
    assign io.done   = state == DONE;
    assign io.result = res;
endmodule

// File: tb/tb_prv32_muldiv_seq.sv
// tb_prv32_muldiv_seq: directed self-checking bench for the RV32M sequencer
module tb_prv32_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, failures = 0;
    prv32_muldiv_seq_if #(.XLEN(32)) bus();
    prv32_muldiv_seq #(.XLEN(32)) dut(.clk(clk), .rst_n(rst_n), .io(bus));
    always #5 clk = ~clk;

    typedef struct {logic [2:0] f; logic [31:0] x, y, e; int l;} vec_t;

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1; bus.funct3 = f; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = 1; nb = 0;
        while (!bus.done && lat < 60) begin
            nb += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vecs(input vec_t v[4], input string tag);
        int lat, nb;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(v[i].f, v[i].x, v[i].y);
            wait_done(lat, nb);
            checks++;
            if (bus.result !== v[i].e) begin
                failures++;
                $display("FAIL %s[%0d] result got=%h exp=%h", tag, i, bus.result, v[i].e);
            end
            checks++;
            if (lat !== v[i].l) begin
                failures++;
                $display("FAIL %s[%0d] latency got=%0d exp=%0d", tag, i, lat, v[i].l);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.result} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL reset rdy/busy/done/result got=%b%b%b/%h exp=100/0", bus.ready, bus.busy, bus.done, bus.result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release rdy/busy/done got=%b%b%b exp=100", bus.ready, bus.busy, bus.done);
        end
    endtask

    task automatic test_mul();
        int lat, nb;
        vec_t v[4] = '{'{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34},
                       '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34},
                       '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34},
                       '{3'd0, 32'h00012345, 32'h00010000, 32'h23450000, 34}};
        @(negedge clk);
        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, nb);
        checks++;
        if (bus.result !== 32'hFFFFFFEB) begin
            failures++;
            $display("FAIL mul result got=%h exp=ffffffeb", bus.result);
        end
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL mul latency got=%0d exp=34", lat);
        end
        checks++;
        if (nb !== 33) begin
            failures++;
            $display("FAIL mul busy_cycles got=%0d exp=33", nb);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.ready, bus.busy} !== 3'b010) begin
            failures++;
            $display("FAIL mul done_pulse done/rdy/busy got=%b%b%b exp=010", bus.done, bus.ready, bus.busy);
        end
        run_vecs(v, "mulh");
    endtask

    task automatic test_div();
        vec_t v[4] = '{'{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34},
                       '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34},
                       '{3'd5, 32'd100, 32'd7, 32'd14, 34},
                       '{3'd7, 32'd100, 32'd7, 32'd2, 34}};
        run_vecs(v, "div");
    endtask

    task automatic test_special();
        vec_t v[4] = '{'{3'd5, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1},
                       '{3'd6, 32'h12345678, 32'h0, 32'h12345678, 1},
                       '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1},
                       '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1}};
        run_vecs(v, "special");
    endtask

    task automatic test_kill();
        int lat, nb, pulses = 0;
        @(negedge clk);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk) bus.kill = 1'b0;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.result} !== {3'b100, 32'h80000000}) begin
            failures++;
            $display("FAIL kill rdy/busy/done/result got=%b%b%b/%h exp=100/80000000", bus.ready, bus.busy, bus.done, bus.result);
        end
        repeat (40) begin
            @(negedge clk);
            pulses += int'(bus.done);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL kill done_pulses got=%0d exp=0", pulses);
        end
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd5);
        wait_done(lat, nb);
        checks++;
        if (bus.result !== 32'd15 || lat !== 34) begin
            failures++;
            $display("FAIL after_kill result/latency got=%h/%0d exp=0000000f/34", bus.result, lat);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue(3'd0, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.result} !== {3'b100, 32'h0}) begin
            failures++;
            $display("FAIL async_reset rdy/busy/done/result got=%b%b%b/%h exp=100/0", bus.ready, bus.busy, bus.done, bus.result);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        @(negedge clk);
        issue(3'd5, 32'd100, 32'd7);
        wait_done(lat, nb);
        checks++;
        if (bus.result !== 32'd14 || lat !== 34) begin
            failures++;
            $display("FAIL b2b_first result/latency got=%h/%0d exp=0000000e/34", bus.result, lat);
        end
        issue(3'd7, 32'd100, 32'd7);
        checks++;
        if ({bus.busy, bus.ready} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_no_idle busy/rdy got=%b%b exp=10", bus.busy, bus.ready);
        end
        wait_done(lat, nb);
        checks++;
        if (bus.result !== 32'd2 || lat !== 34) begin
            failures++;
            $display("FAIL b2b_second result/latency got=%h/%0d exp=00000002/34", bus.result, lat);
        end
        issue(3'd5, 32'h12345678, 32'h0);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL b2b_special done/result got=%b/%h exp=1/ffffffff", bus.done, bus.result);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
